// File: rtl/pci_arb_pkg.sv
// Shared types and defaults for the PCI-style round-robin bus arbiter.
// Imported by the arbiter top and its rr_pick helper, and by the bus top level.
package pci_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_TENURE = 16;
    localparam int ARB_STATE_W    = 2;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_TURN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/pci_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request scanning from ptr upward,
// wrapping modulo NUM_REQ.
module rr_pick
    import pci_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int OWNER_W = $clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [OWNER_W-1:0] pick,
    output logic               any_req
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [OWNER_W:0]     sum;

    // Rotate so that bit 0 is the ptr position; lowest rotated bit wins.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[NUM_REQ-1:0];
    assign any_req = |req;

    always_comb begin
        pick = '0;
        sum  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                sum = {1'b0, ptr} + (OWNER_W+1)'(i);
                if (sum >= (OWNER_W+1)'(NUM_REQ)) begin
                    sum = sum - (OWNER_W+1)'(NUM_REQ);
                end
                pick = sum[OWNER_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Round-robin system bus arbiter with registered one-hot grants, bounded tenure and a
// one-cycle turnaround. Define ARB_PARK_EN to park the idle bus on requester 0 (CPU).
module pci_bus_arbiter
    import pci_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAX_TENURE = DEF_MAX_TENURE,
    parameter int OWNER_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [OWNER_W-1:0] owner,
    output logic               bus_busy,
    output logic               preempt
);

`ifdef ARB_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif
    localparam int                 CNT_W    = $clog2(MAX_TENURE + 2);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    arb_state_e         state_q, state_d;
    logic [OWNER_W-1:0] ptr_q, ptr_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               preempt_q, preempt_d;

    logic [OWNER_W-1:0] pick;
    logic               any_req;
    logic               own_req, others_req, expired, park_hop;
    logic [OWNER_W:0]   owner_inc;
    logic [OWNER_W-1:0] ptr_wrap;
    logic [NUM_REQ-1:0] grant_oh;

    rr_pick #(.NUM_REQ(NUM_REQ), .OWNER_W(OWNER_W)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .pick    (pick),
        .any_req (any_req)
    );

    // gnt_q is the owner's one-hot while in GRANT, so it doubles as the owner mask.
    assign own_req    = |(req & gnt_q);
    assign others_req = |(req & ~gnt_q);
    // >= rather than == so a requester that arrives after the counter saturated still
    // gets the bus instead of waiting behind an unbounded tenure.
    assign expired    = (MAX_TENURE != 0) && (int'(cnt_q) >= MAX_TENURE - 1) && others_req;
    assign owner_inc  = {1'b0, owner_q} + (OWNER_W+1)'(1);
    assign ptr_wrap   = (owner_inc >= (OWNER_W+1)'(NUM_REQ)) ? '0 : owner_inc[OWNER_W-1:0];
    assign grant_oh   = ONE_HOT0 << pick;
    assign park_hop   = PARK && (state_q == ARB_IDLE) && gnt_q[0] && (pick != '0);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        case (state_q)
            ARB_IDLE, ARB_TURN: begin
                if (any_req && park_hop) begin
                    // Parked grant must drop for a turnaround before another master drives.
                    gnt_d   = '0;
                    state_d = ARB_TURN;
                end else if (any_req) begin
                    gnt_d   = grant_oh;
                    owner_d = pick;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ARB_GRANT;
                end else begin
                    gnt_d   = PARK ? ONE_HOT0 : '0;
                    if (PARK) owner_d = '0;
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (!own_req || expired) begin
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    ptr_d     = ptr_wrap;
                    preempt_d = own_req;
                    state_d   = ARB_TURN;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign bus_busy = busy_q;
    assign preempt  = preempt_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Bench for pci_bus_arbiter: two instances (unlimited tenure, tenure 4) share one req bus
// and are compared every cycle against a grant/owner reference model.
module tb_pci_bus_arbiter;

`ifdef ARB_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] own_a, own_b;
    logic       busy_a, busy_b, pre_a, pre_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pci_bus_arbiter #(.NUM_REQ(4), .MAX_TENURE(0), .OWNER_W(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .req(req),
        .gnt(gnt_a), .owner(own_a), .bus_busy(busy_a), .preempt(pre_a)
    );
    pci_bus_arbiter #(.NUM_REQ(4), .MAX_TENURE(4), .OWNER_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(req),
        .gnt(gnt_b), .owner(own_b), .bus_busy(busy_b), .preempt(pre_b)
    );

    // Reference model: who holds the bus (-1 = nobody), how many cycles it has held it,
    // the rotating priority start, last grantee, parked flag and preempt pulse.
    int m_own[2]  = '{-1, -1};
    int m_ten[2]  = '{0, 0};
    int m_ptr[2]  = '{0, 0};
    int m_last[2] = '{0, 0};
    bit m_park[2] = '{1'b0, 1'b0};
    bit m_pre[2]  = '{1'b0, 1'b0};
    int mt[2]     = '{0, 4};

    function automatic int first_req(int p, logic [3:0] r);
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [7:0] mexp(int c);
        logic [3:0] g;
        g = 4'b0000;
        if (m_own[c] >= 0) g = 4'b0001 << m_own[c];
        else if (m_park[c]) g = 4'b0001;
        return {g, 2'(m_last[c]), (m_own[c] >= 0), m_pre[c]};
    endfunction

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            m_pre[c] = 1'b0;
            if (!reset_n) begin
                m_own[c] = -1; m_ten[c] = 0; m_ptr[c] = 0; m_last[c] = 0; m_park[c] = 1'b0;
            end else if (m_own[c] >= 0) begin
                int o = m_own[c];
                if (!req[o] || (mt[c] != 0 && m_ten[c] >= mt[c] && (req & ~(4'b0001 << o)) != 4'b0000)) begin
                    m_pre[c] = req[o];
                    m_ptr[c] = (o + 1) % 4;
                    m_own[c] = -1;
                end else begin
                    m_ten[c]++;
                end
            end else if (req != 4'b0000) begin
                int p = first_req(m_ptr[c], req);
                if (PARK && m_park[c] && p != 0) begin
                    m_park[c] = 1'b0;
                end else begin
                    m_own[c] = p; m_last[c] = p; m_ten[c] = 1; m_park[c] = 1'b0;
                end
            end else if (PARK) begin
                m_park[c] = 1'b1; m_last[c] = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = 4'b1111;
        step();
        step();
        n_checks++;
        if ({gnt_a, own_a, busy_a, pre_a} !== 8'h00)
            $display("FAIL reset_a got %h want 00", {gnt_a, own_a, busy_a, pre_a});
        else n_pass++;
        n_checks++;
        if ({gnt_b, own_b, busy_b, pre_b} !== 8'h00)
            $display("FAIL reset_b got %h want 00", {gnt_b, own_b, busy_b, pre_b});
        else n_pass++;
        req = 4'b0000;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0010;
        step();
        n_checks++;
        if (gnt_a !== 4'b0010 || own_a !== 2'd1 || busy_a !== 1'b1)
            $display("FAIL single_grant got gnt=%b own=%0d busy=%b want 0010/1/1", gnt_a, own_a, busy_a);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) req = 4'b0000;
            step();
            n_checks++;
            if ({gnt_a, own_a, busy_a, pre_a} !== mexp(0))
                $display("FAIL single_a cyc%0d got %h want %h", i, {gnt_a, own_a, busy_a, pre_a}, mexp(0));
            else n_pass++;
            if (i == 3) begin
                n_checks++;
                if (gnt_a !== 4'b0000 || own_a !== 2'd1 || busy_a !== 1'b0)
                    $display("FAIL single_release got gnt=%b own=%0d busy=%b want 0000/1/0", gnt_a, own_a, busy_a);
                else n_pass++;
            end
        end
    endtask

    task automatic test_rotation();
        int order[$];
        int gaps[$];
        int gap = 0;
        logic [3:0] prev = 4'b0000;
        do_reset();
        req = 4'b1011;
        for (int i = 0; i < 30; i++) begin
            step();
            n_checks++;
            if ({gnt_a, own_a, busy_a, pre_a} !== mexp(0))
                $display("FAIL rot_a cyc%0d got %h want %h", i, {gnt_a, own_a, busy_a, pre_a}, mexp(0));
            else n_pass++;
            if (gnt_a != 4'b0000 && prev == 4'b0000) begin
                for (int k = 0; k < 4; k++) if (gnt_a[k]) order.push_back(k);
                if (order.size() > 1) gaps.push_back(gap);
                gap = 0;
            end else if (gnt_a == 4'b0000 && order.size() > 0) begin
                gap++;
            end
            prev = gnt_a;
            req = (m_own[0] >= 0 && m_ten[0] == 3) ? (4'b1011 & ~(4'b0001 << m_own[0])) : 4'b1011;
        end
        n_checks++;
        if (order.size() < 4 || order[0] != 0 || order[1] != 1 || order[2] != 3 || order[3] != 0)
            $display("FAIL rot_order got %p want 0,1,3,0", order);
        else n_pass++;
        n_checks++;
        if (gaps.size() < 3 || gaps[0] != 1 || gaps[1] != 1 || gaps[2] != 1)
            $display("FAIL rot_gaps got %p want 1,1,1", gaps);
        else n_pass++;
    endtask

    task automatic test_tenure();
        do_reset();
        req = 4'b0101;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            int pos = (cyc - 1) % 10;
            logic [3:0] eg;
            logic       ep;
            step();
            eg = (pos < 4) ? 4'b0001 : (pos == 4) ? 4'b0000 : (pos < 9) ? 4'b0100 : 4'b0000;
            ep = (pos == 4) || (pos == 9);
            n_checks++;
            if (gnt_b !== eg || pre_b !== ep)
                $display("FAIL tenure cyc%0d got gnt=%b pre=%b want gnt=%b pre=%b", cyc, gnt_b, pre_b, eg, ep);
            else n_pass++;
            n_checks++;
            if ({gnt_a, own_a, busy_a, pre_a} !== mexp(0))
                $display("FAIL tenure_a cyc%0d got %h want %h", cyc, {gnt_a, own_a, busy_a, pre_a}, mexp(0));
            else n_pass++;
        end
    endtask

    task automatic test_lone();
        int bad = 0;
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 40; i++) begin
            step();
            if (gnt_b !== 4'b1000 || pre_b !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL lone got %0d bad cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if ({gnt_b, own_b, busy_b, pre_b} !== mexp(1))
            $display("FAIL lone_b got %h want %h", {gnt_b, own_b, busy_b, pre_b}, mexp(1));
        else n_pass++;
        req = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        step();
        step();
        reset_n = 1'b0;
        step();
        n_checks++;
        if ({gnt_a, own_a, busy_a, pre_a} !== 8'h00)
            $display("FAIL midreset got %h want 00", {gnt_a, own_a, busy_a, pre_a});
        else n_pass++;
        reset_n = 1'b1;
        step();
        n_checks++;
        if (gnt_a !== 4'b0010 || busy_a !== 1'b1)
            $display("FAIL midreset_regrant got gnt=%b busy=%b want 0010/1", gnt_a, busy_a);
        else n_pass++;
        req = 4'b0000;
    endtask

`ifdef ARB_PARK_EN
    task automatic test_park();
        logic [3:0] eg[8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000};
        logic [3:0] rq[8] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100};
        logic       eb[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req = rq[i];
            if (i == 7) reset_n = 1'b0;
            step();
            n_checks++;
            if (gnt_a !== eg[i] || busy_a !== eb[i])
                $display("FAIL park step%0d got gnt=%b busy=%b want gnt=%b busy=%b", i, gnt_a, busy_a, eg[i], eb[i]);
            else n_pass++;
        end
        reset_n = 1'b1;
        req = 4'b0000;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [3:0] flip = 4'b0000;
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 3) == 0) flip[k] = 1'b1;
            req = req ^ flip;
            reset_n = ($urandom_range(0, 99) != 0);
            step();
            n_checks++;
            if ({gnt_a, own_a, busy_a, pre_a} !== mexp(0))
                $display("FAIL rand_a cyc%0d got %h want %h", i, {gnt_a, own_a, busy_a, pre_a}, mexp(0));
            else n_pass++;
            n_checks++;
            if ({gnt_b, own_b, busy_b, pre_b} !== mexp(1))
                $display("FAIL rand_b cyc%0d got %h want %h", i, {gnt_b, own_b, busy_b, pre_b}, mexp(1));
            else n_pass++;
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_tenure();
        test_lone();
        test_reset_mid();
`ifdef ARB_PARK_EN
        test_park();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
